// File: rtl/systolic_output_deskew.sv
// rtl/systolic_output_deskew.sv - realigns the diagonal result wavefront of a systolic array into whole rows
//
// Purpose:
//   The PE array produces results skewed in time: column lane i becomes valid
//   i cycles after lane 0. Each lane i is delayed by N-i enabled cycles, so all
//   lanes of one result row leave together as one aligned word. A valid pipeline
//   tracks which cycles carry a complete row. A row counter marks the last row
//   of each tile for the writeback stage.
//
// Ports:
//   CLK        in   clock, rising edge
//   ASYNC_RST  in   asynchronous active-low reset
//   SYNC_RST   in   synchronous clear, active-high, only acts when EN=1
//   EN         in   global advance; 0 freezes every register
//   In_Valid   in   lane 0 of a new wavefront row is present this cycle
//   In         in   skewed lane data, lane i = In[i*DATA_WIDTH +: DATA_WIDTH]
//   Out        out  aligned row, same lane packing as In
//   Out_Valid  out  Out holds a complete aligned row
//   Out_Last   out  Out_Valid for the final row of a tile
//   Busy       out  at least one row is in flight
module systolic_output_deskew #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ROWS       = 4
) (
  input  logic                  CLK,
  input  logic                  ASYNC_RST,
  input  logic                  SYNC_RST,
  input  logic                  EN,
  input  logic                  In_Valid,
  input  logic [N*DATA_WIDTH-1:0] In,
  output logic [N*DATA_WIDTH-1:0] Out,
  output logic                  Out_Valid,
  output logic                  Out_Last,
  output logic                  Busy
);

  // A single-row tile still needs a one-bit counter so the width stays legal.
  localparam int CW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [CW-1:0] LAST_ROW = CW'(ROWS - 1);

  logic [N-1:0]  valid_pipe;
  logic [CW-1:0] row_cnt;

  // Lane i waits N-i cycles. Lane 0 arrives first and waits longest.
  // Lane N-1 arrives last and waits one register. Every path from In to Out
  // therefore crosses at least one flop.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      localparam int DEPTH = N - gi;
      logic [DATA_WIDTH-1:0] dly [DEPTH];

      always_ff @(posedge CLK or negedge ASYNC_RST) begin
        if (!ASYNC_RST) begin
          for (int s = 0; s < DEPTH; s++) dly[s] <= '0;
        end else if (EN) begin
          if (SYNC_RST) begin
            for (int s = 0; s < DEPTH; s++) dly[s] <= '0;
          end else begin
            // Lanes other than 0 are sampled every enabled cycle. Their timing
            // is implied by lane 0's In_Valid.
            dly[0] <= In[gi*DATA_WIDTH +: DATA_WIDTH];
            for (int s = 1; s < DEPTH; s++) dly[s] <= dly[s-1];
          end
        end
      end

      assign Out[gi*DATA_WIDTH +: DATA_WIDTH] = dly[DEPTH-1];
    end
  endgenerate

  // The valid pipeline has the same depth as lane 0. Its tail lines up with
  // the moment the last lane of the same row reaches the output.
  always_ff @(posedge CLK or negedge ASYNC_RST) begin
    if (!ASYNC_RST) begin
      valid_pipe <= '0;
    end else if (EN) begin
      if (SYNC_RST) begin
        valid_pipe <= '0;
      end else begin
        valid_pipe[0] <= In_Valid;
        for (int s = 1; s < N; s++) valid_pipe[s] <= valid_pipe[s-1];
      end
    end
  end

  // Counts rows as they leave. The counter value shown with a row is that
  // row's index within its tile.
  always_ff @(posedge CLK or negedge ASYNC_RST) begin
    if (!ASYNC_RST) begin
      row_cnt <= '0;
    end else if (EN) begin
      if (SYNC_RST) begin
        row_cnt <= '0;
      end else if (Out_Valid) begin
        row_cnt <= (row_cnt == LAST_ROW) ? '0 : row_cnt + 1'b1;
      end
    end
  end

  assign Out_Valid = valid_pipe[N-1];
  assign Out_Last  = Out_Valid && (row_cnt == LAST_ROW);
  assign Busy      = |valid_pipe;

endmodule

// File: tb/tb_systolic_output_deskew.sv
// tb/tb_systolic_output_deskew.sv - scoreboard bench for systolic_output_deskew
module tb_systolic_output_deskew;

  localparam int NA = 4;
  localparam int DW = 32;
  localparam int RA = 4;
  localparam int WA = NA * DW;

  logic          CLK = 1'b0;
  logic          ASYNC_RST = 1'b0;
  logic          SYNC_RST = 1'b0;
  logic          EN = 1'b0;
  logic          In_Valid = 1'b0;
  logic [WA-1:0] In = '0;
  logic [WA-1:0] Out;
  logic          Out_Valid, Out_Last, Busy;

  logic          b_sync = 1'b0;
  logic          b_en = 1'b1;
  logic          b_in_valid = 1'b0;
  logic [DW-1:0] b_in = '0;
  logic [DW-1:0] b_out;
  logic          b_valid, b_last, b_busy;

  systolic_output_deskew #(.N(NA), .DATA_WIDTH(DW), .ROWS(RA)) dut (
    .CLK(CLK), .ASYNC_RST(ASYNC_RST), .SYNC_RST(SYNC_RST), .EN(EN),
    .In_Valid(In_Valid), .In(In), .Out(Out), .Out_Valid(Out_Valid),
    .Out_Last(Out_Last), .Busy(Busy)
  );

  systolic_output_deskew #(.N(1), .DATA_WIDTH(DW), .ROWS(1)) dut_n1 (
    .CLK(CLK), .ASYNC_RST(ASYNC_RST), .SYNC_RST(b_sync), .EN(b_en),
    .In_Valid(b_in_valid), .In(b_in), .Out(b_out), .Out_Valid(b_valid),
    .Out_Last(b_last), .Busy(b_busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [WA-1:0] data;
    bit            last;
    int            due;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  int            tests = 0;
  int            fails = 0;
  int            ecyc = 0;
  bit            edge_en = 0;
  int            tb_row = 0;
  logic [WA-1:0] hist_row [NA];
  bit            hist_v [NA];

  // Enabled-edge counter: the time base that all expected due cycles use.
  always @(posedge CLK) begin
    edge_en = ASYNC_RST && EN;
    if (edge_en) ecyc++;
  end

  // Scoreboard monitor: runs after each enabled edge and pops on Out_Valid.
  always @(posedge CLK) begin
    #3;
    if (edge_en) begin
      if (Out_Valid) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL sb_unexpected: Out_Valid=1 Out=%h at cycle %0d, required no row", Out, ecyc);
        end else begin
          mon_e = sb.pop_front();
          if (Out !== mon_e.data || Out_Last !== mon_e.last || ecyc !== mon_e.due) begin
            fails++;
            $display("FAIL sb_row: got Out=%h last=%0b cycle=%0d, required Out=%h last=%0b cycle=%0d",
                     Out, Out_Last, ecyc, mon_e.data, mon_e.last, mon_e.due);
          end
        end
      end else if (sb.size() > 0 && sb[0].due <= ecyc) begin
        tests++;
        fails++;
        $display("FAIL sb_missing: Out_Valid=0 at cycle %0d, required row %h due %0d", ecyc, sb[0].data, sb[0].due);
        void'(sb.pop_front());
      end
    end
  end

  function automatic logic [WA-1:0] mk_row(input int r);
    logic [WA-1:0] w;
    for (int k = 0; k < NA; k++) w[k*DW +: DW] = DW'(r * 16 + k);
    return w;
  endfunction

  task automatic clear_model();
    sb.delete();
    tb_row = 0;
    for (int k = 0; k < NA; k++) begin
      hist_row[k] = '0;
      hist_v[k] = 0;
    end
  endtask

  // One cycle of stimulus. It presents the skewed lanes of the rows in flight
  // and pushes the expected aligned row into the scoreboard.
  task automatic drive(input bit en, input bit v, input logic [WA-1:0] row, input bit srst);
    logic [WA-1:0] word;
    @(negedge CLK);
    EN = en;
    SYNC_RST = srst;
    if (en) begin
      for (int k = NA - 1; k > 0; k--) begin
        hist_row[k] = hist_row[k-1];
        hist_v[k] = hist_v[k-1];
      end
      hist_row[0] = row;
      hist_v[0] = v;
      word = '0;
      for (int k = 0; k < NA; k++)
        if (hist_v[k]) word[k*DW +: DW] = hist_row[k][k*DW +: DW];
      In = word;
      In_Valid = v;
      if (srst) begin
        clear_model();
      end else if (v) begin
        sb.push_back('{data: row, last: (tb_row == RA - 1), due: ecyc + NA});
        tb_row = (tb_row + 1) % RA;
      end
    end else begin
      In = {$urandom, $urandom, $urandom, $urandom};
      In_Valid = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1, 0, '0, 0);
  endtask

  task automatic do_areset();
    @(negedge CLK);
    ASYNC_RST = 1'b0;
    EN = 1'b0;
    SYNC_RST = 1'b0;
    In_Valid = 1'b0;
    In = '0;
    clear_model();
    @(negedge CLK);
    ASYNC_RST = 1'b1;
  endtask

  task automatic test_reset();
    #12;
    tests++;
    if (Out !== '0 || Out_Valid !== 1'b0 || Out_Last !== 1'b0 || Busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_hold: Out=%h V=%b L=%b B=%b, required all 0", Out, Out_Valid, Out_Last, Busy);
    end
    @(negedge CLK);
    ASYNC_RST = 1'b1;
    idle(3);
    @(posedge CLK);
    #3;
    tests++;
    if (Out !== '0 || Out_Valid !== 1'b0 || Out_Last !== 1'b0 || Busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_after: Out=%h V=%b L=%b B=%b, required all 0", Out, Out_Valid, Out_Last, Busy);
    end
  endtask

  task automatic test_single_row();
    logic [WA-1:0] row1;
    row1 = {32'h44, 32'h33, 32'h22, 32'h11};
    do_areset();
    drive(1, 1, row1, 0);
    @(posedge CLK);
    #3;
    tests++;
    if (Busy !== 1'b1) begin
      fails++;
      $display("FAIL single_busy: Busy=%b, required 1", Busy);
    end
    idle(NA + 3);
    tests++;
    if (sb.size() != 0 || Busy !== 1'b0) begin
      fails++;
      $display("FAIL single_drain: pending=%0d Busy=%b, required 0 and 0", sb.size(), Busy);
    end
  endtask

  task automatic test_back_to_back();
    do_areset();
    for (int r = 0; r < 5; r++) drive(1, 1, mk_row(r + 1), 0);
    idle(NA + 2);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL b2b_drain: pending=%0d, required 0", sb.size());
    end
  endtask

  task automatic test_stall();
    logic [WA+2:0] snap;
    do_areset();
    drive(1, 1, {32'h44, 32'h33, 32'h22, 32'h11}, 0);
    drive(1, 0, '0, 0);
    drive(1, 0, '0, 0);
    @(posedge CLK);
    #3;
    snap = {Out, Out_Valid, Out_Last, Busy};
    tests++;
    if (Busy !== 1'b1) begin
      fails++;
      $display("FAIL stall_busy: Busy=%b, required 1", Busy);
    end
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, '0, 0);
      @(posedge CLK);
      #3;
      tests++;
      if ({Out, Out_Valid, Out_Last, Busy} !== snap) begin
        fails++;
        $display("FAIL stall_hold%0d: outputs=%h, required %h", k, {Out, Out_Valid, Out_Last, Busy}, snap);
      end
    end
    idle(NA + 2);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL stall_drain: pending=%0d, required 0", sb.size());
    end
  endtask

  task automatic test_sync_reset();
    do_areset();
    drive(1, 1, mk_row(1), 0);
    drive(1, 1, mk_row(2), 0);
    drive(1, 0, '0, 0);
    drive(1, 1, mk_row(7), 1);
    @(posedge CLK);
    #3;
    tests++;
    if (Out !== '0 || Out_Valid !== 1'b0 || Busy !== 1'b0) begin
      fails++;
      $display("FAIL srst_clear: Out=%h V=%b B=%b, required 0 0 0", Out, Out_Valid, Busy);
    end
    for (int r = 0; r < RA; r++) drive(1, 1, mk_row(r + 3), 0);
    idle(NA + 2);
    drive(1, 1, mk_row(9), 0);
    drive(1, 1, mk_row(10), 0);
    drive(0, 0, '0, 1);
    idle(NA + 2);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL srst_en0_drain: pending=%0d, required 0", sb.size());
    end
  endtask

  task automatic test_async_reset();
    do_areset();
    drive(1, 1, mk_row(4), 0);
    drive(1, 1, mk_row(5), 0);
    drive(1, 1, mk_row(6), 0);
    drive(1, 0, '0, 0);
    @(posedge CLK);
    #2;
    tests++;
    if (Busy !== 1'b1) begin
      fails++;
      $display("FAIL arst_pre_busy: Busy=%b, required 1", Busy);
    end
    clear_model();
    ASYNC_RST = 1'b0;
    #1;
    tests++;
    if (Out !== '0 || Out_Valid !== 1'b0 || Out_Last !== 1'b0 || Busy !== 1'b0) begin
      fails++;
      $display("FAIL arst_now: Out=%h V=%b L=%b B=%b, required all 0", Out, Out_Valid, Out_Last, Busy);
    end
    @(negedge CLK);
    ASYNC_RST = 1'b1;
    for (int k = 0; k < NA + 2; k++) begin
      drive(1, 0, '0, 0);
      @(posedge CLK);
      #3;
      tests++;
      if (Out_Valid !== 1'b0) begin
        fails++;
        $display("FAIL arst_stale%0d: Out_Valid=%b, required 0", k, Out_Valid);
      end
    end
  endtask

  task automatic test_n1();
    logic [DW-1:0] q[$];
    @(negedge CLK);
    b_in = 32'hABCD;
    b_in_valid = 1'b1;
    q.push_back(32'hABCD);
    @(negedge CLK);
    b_in = 32'h0;
    b_in_valid = 1'b0;
    #2;
    tests++;
    if (b_valid !== 1'b1 || b_out !== q[0] || b_last !== 1'b1 || b_busy !== 1'b1) begin
      fails++;
      $display("FAIL n1_row: Out=%h V=%b L=%b B=%b, required %h 1 1 1", b_out, b_valid, b_last, b_busy, q[0]);
    end
    void'(q.pop_front());
    @(negedge CLK);
    #2;
    tests++;
    if (b_valid !== 1'b0 || b_busy !== 1'b0 || b_last !== 1'b0) begin
      fails++;
      $display("FAIL n1_after: V=%b L=%b B=%b, required 0 0 0", b_valid, b_last, b_busy);
    end
  endtask

  initial begin
    clear_model();
    test_reset();
    test_single_row();
    test_back_to_back();
    test_stall();
    test_sync_reset();
    test_async_reset();
    test_n1();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule
